// File: rtl/instruction_fetch_data_if.sv
// Instruction-memory line-read bus between the fetch data stage and memory.
//
// Signals:
//   mem_rd_req    fetch -> mem   line read request, held until accepted
//   mem_rd_addr   fetch -> mem   line-aligned byte address
//   mem_rd_ack    mem -> fetch   request accepted
//   mem_rd_valid  mem -> fetch   one data beat valid
//   mem_rd_data   mem -> fetch   beat data, ascending word order
//
// The master modport is used by the fetch stage; the slave modport by memory.

interface instruction_fetch_data_if;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ack;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;

    modport master (
        output mem_rd_req,
        output mem_rd_addr,
        input  mem_rd_ack,
        input  mem_rd_valid,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_req,
        input  mem_rd_addr,
        output mem_rd_ack,
        output mem_rd_valid,
        output mem_rd_data
    );
endinterface

// File: rtl/instruction_fetch_data.sv
// Second instruction-fetch stage. Compares the tag-stage tags against the
// registered fetch PC, returns the hit word to ID, and on a miss fills one
// cache line from instruction memory before handing the new tag back to the
// tag stage.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   ift_valid                     a fetch is presented this cycle
//   ift_ifd_fetched_pc            fetched PC (tag | set | word | byte)
//   ift_ifd_valid_bits            per-way valid bits for the fetched set
//   ift_ifd_tags_read             per-way tags for the fetched set
//   wb_do_branch                  redirect; squashes the fetch in flight
//   ifd_ift_cache_miss            combinational miss pulse to the tag stage
//   ifd_ift_resume_fetch          one-cycle pulse when the fill is done
//   ifd_ift_cache_fetch_fsm_idle  fill FSM idle
//   ifd_ift_update_tag_en         per-way tag write strobe
//   ifd_ift_update_tag_set        set to write
//   ifd_ift_update_tag            tag to write
//   mem                           line-read bus (master side)
//   ifd_id_valid/instr/pc         registered instruction to ID
//
// Fill FSM:
//   state      | meaning
//   ST_IDLE    | no fill outstanding; a miss starts one
//   ST_REQ     | line request held on the bus until acked
//   ST_FILL    | collecting LINE_WORDS beats into the victim way
//   ST_UPDATE  | one cycle: write new tag into the tag stage
//   ST_RESUME  | one cycle: tell the tag stage to restart fetch

module instruction_fetch_data #(
    parameter  int ICACHE_NUM_WAYS     = 2,
    parameter  int ICACHE_NUM_SETS     = 64,
    parameter  int ICACHE_LINE_WORDS   = 8,
    localparam int ICACHE_NUM_SET_BITS = $clog2(ICACHE_NUM_SETS),
    localparam int ICACHE_OFF_BITS     = $clog2(ICACHE_LINE_WORDS),
    localparam int ICACHE_NUM_TAG_BITS = 32 - ICACHE_NUM_SET_BITS - ICACHE_OFF_BITS - 2
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              ift_valid,
    input  logic [31:0]                                       ift_ifd_fetched_pc,
    input  logic [ICACHE_NUM_WAYS-1:0]                        ift_ifd_valid_bits,
    input  logic [ICACHE_NUM_WAYS-1:0][ICACHE_NUM_TAG_BITS-1:0] ift_ifd_tags_read,
    input  logic                                              wb_do_branch,
    output logic                                              ifd_ift_cache_miss,
    output logic                                              ifd_ift_resume_fetch,
    output logic                                              ifd_ift_cache_fetch_fsm_idle,
    output logic [ICACHE_NUM_WAYS-1:0]                        ifd_ift_update_tag_en,
    output logic [ICACHE_NUM_SET_BITS-1:0]                    ifd_ift_update_tag_set,
    output logic [ICACHE_NUM_TAG_BITS-1:0]                    ifd_ift_update_tag,
    instruction_fetch_data_if.master                          mem,
    output logic                                              ifd_id_valid,
    output logic [31:0]                                       ifd_id_instr,
    output logic [31:0]                                       ifd_id_pc
);

    localparam int WAY_BITS   = (ICACHE_NUM_WAYS > 1) ? $clog2(ICACHE_NUM_WAYS) : 1;
    localparam int LINE_BITS  = 32 - ICACHE_OFF_BITS - 2;
    localparam int IDX_BITS   = ICACHE_NUM_SET_BITS + ICACHE_OFF_BITS;
    localparam int RAM_DEPTH  = ICACHE_NUM_SETS * ICACHE_LINE_WORDS;

    localparam logic [ICACHE_OFF_BITS-1:0] LAST_BEAT = ICACHE_OFF_BITS'(ICACHE_LINE_WORDS - 1);
    localparam logic [WAY_BITS-1:0]        LAST_WAY  = WAY_BITS'(ICACHE_NUM_WAYS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_UPDATE,
        ST_RESUME
    } fill_state_t;

    fill_state_t state, state_nxt;

    logic [ICACHE_OFF_BITS-1:0]     beat_cnt;
    logic [WAY_BITS-1:0]            rr_ptr;
    logic [LINE_BITS-1:0]           miss_line;
    logic [ICACHE_NUM_SET_BITS-1:0] miss_set;
    logic [ICACHE_NUM_TAG_BITS-1:0] miss_tag;

    logic [ICACHE_NUM_TAG_BITS-1:0] pc_tag;
    logic [ICACHE_NUM_SET_BITS-1:0] pc_set;
    logic [ICACHE_OFF_BITS-1:0]     pc_word;
    logic [IDX_BITS-1:0]            rd_idx;
    logic [1:0]                     unused_pc_byte;

    logic [ICACHE_NUM_WAYS-1:0]     hit;
    logic                           hit_any;
    logic                           miss;
    logic [31:0]                    hit_word;

    logic [31:0] data_ram [ICACHE_NUM_WAYS][RAM_DEPTH];

    // ------------------------------------------------------------------
    // Address split and way-hit detection
    // ------------------------------------------------------------------
    assign pc_tag         = ift_ifd_fetched_pc[31 -: ICACHE_NUM_TAG_BITS];
    assign pc_set         = ift_ifd_fetched_pc[ICACHE_OFF_BITS+2 +: ICACHE_NUM_SET_BITS];
    assign pc_word        = ift_ifd_fetched_pc[2 +: ICACHE_OFF_BITS];
    assign unused_pc_byte = ift_ifd_fetched_pc[1:0];
    assign rd_idx         = {pc_set, pc_word};

    always_comb begin
        hit = '0;
        for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
            hit[w] = ift_valid && ift_ifd_valid_bits[w] &&
                     (ift_ifd_tags_read[w] == pc_tag);
        end
    end

    assign hit_any = |hit;

    // Misses are only taken while idle; otherwise the tag stage has already
    // stalled and the presented fetch is stale.
    assign miss = ift_valid && !hit_any && (state == ST_IDLE) && !wb_do_branch;

    always_comb begin
        hit_word = '0;
        for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
            if (hit[w]) begin
                hit_word = data_ram[w][rd_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Data ways: combinational read, written one beat at a time during fill
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((state == ST_FILL) && mem.mem_rd_valid) begin
            data_ram[rr_ptr][{miss_set, beat_cnt}] <= mem.mem_rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Fill FSM
    // ------------------------------------------------------------------
    assign miss_set = miss_line[ICACHE_NUM_SET_BITS-1:0];
    assign miss_tag = miss_line[LINE_BITS-1 -: ICACHE_NUM_TAG_BITS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt                    = state;
        mem.mem_rd_req               = 1'b0;
        ifd_ift_cache_fetch_fsm_idle = 1'b0;
        ifd_ift_update_tag_en        = '0;
        ifd_ift_resume_fetch         = 1'b0;
        case (state)
            ST_IDLE: begin
                ifd_ift_cache_fetch_fsm_idle = 1'b1;
                if (miss) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                mem.mem_rd_req = 1'b1;
                if (mem.mem_rd_ack) begin
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem.mem_rd_valid && (beat_cnt == LAST_BEAT)) begin
                    state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                ifd_ift_update_tag_en[rr_ptr] = 1'b1;
                state_nxt                     = ST_RESUME;
            end
            ST_RESUME: begin
                ifd_ift_resume_fetch = 1'b1;
                state_nxt            = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ifd_ift_cache_miss     = miss;
    assign ifd_ift_update_tag_set = miss_set;
    assign ifd_ift_update_tag     = miss_tag;
    assign mem.mem_rd_addr        = {miss_line, {(ICACHE_OFF_BITS + 2){1'b0}}};

    // Victim is the round-robin pointer itself; it only moves in UPDATE, so
    // it is stable for the whole fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt  <= '0;
            rr_ptr    <= '0;
            miss_line <= '0;
        end else begin
            if (miss) begin
                miss_line <= ift_ifd_fetched_pc[31 -: LINE_BITS];
            end
            if ((state == ST_FILL) && mem.mem_rd_valid) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state == ST_UPDATE) begin
                rr_ptr <= (rr_ptr == LAST_WAY) ? '0 : rr_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered output to ID
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifd_id_valid <= 1'b0;
            ifd_id_instr <= '0;
            ifd_id_pc    <= '0;
        end else begin
            ifd_id_valid <= hit_any && !wb_do_branch;
            if (hit_any && !wb_do_branch) begin
                ifd_id_instr <= hit_word;
                ifd_id_pc    <= ift_ifd_fetched_pc;
            end
        end
    end

    // Tag stage guarantees a line lives in at most one way.
    a_onehot_hit : assert property (@(posedge clk) disable iff (!rst) $onehot0(hit));

endmodule

// File: tb/tb_instruction_fetch_data.sv
module tb_instruction_fetch_data;

    localparam int WAYS     = 2;
    localparam int SET_BITS = 6;
    localparam int TAG_BITS = 21;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic                           ift_valid;
    logic [31:0]                    fetched_pc;
    logic [WAYS-1:0]                valid_bits;
    logic [WAYS-1:0][TAG_BITS-1:0]  tags_read;
    logic                           wb_do_branch;
    logic                           cache_miss;
    logic                           resume_fetch;
    logic                           fsm_idle;
    logic [WAYS-1:0]                update_tag_en;
    logic [SET_BITS-1:0]            update_tag_set;
    logic [TAG_BITS-1:0]            update_tag;
    logic                           id_valid;
    logic [31:0]                    id_instr;
    logic [31:0]                    id_pc;

    instruction_fetch_data_if mem_if ();

    instruction_fetch_data dut (
        .clk                          (clk),
        .rst                          (rst),
        .ift_valid                    (ift_valid),
        .ift_ifd_fetched_pc           (fetched_pc),
        .ift_ifd_valid_bits           (valid_bits),
        .ift_ifd_tags_read            (tags_read),
        .wb_do_branch                 (wb_do_branch),
        .ifd_ift_cache_miss           (cache_miss),
        .ifd_ift_resume_fetch         (resume_fetch),
        .ifd_ift_cache_fetch_fsm_idle (fsm_idle),
        .ifd_ift_update_tag_en        (update_tag_en),
        .ifd_ift_update_tag_set       (update_tag_set),
        .ifd_ift_update_tag           (update_tag),
        .mem                          (mem_if),
        .ifd_id_valid                 (id_valid),
        .ifd_id_instr                 (id_instr),
        .ifd_id_pc                    (id_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Drives a line fill starting at a negedge with the FSM in REQ. Returns
    // at the negedge where the FSM sits in UPDATE.
    task automatic serve_fill(input logic [31:0] base, input int ack_delay, input int branch_beat);
        repeat (ack_delay) @(negedge clk);
        mem_if.mem_rd_ack = 1'b1;
        @(negedge clk);
        mem_if.mem_rd_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_if.mem_rd_valid = 1'b1;
            mem_if.mem_rd_data  = base + 32'(i);
            wb_do_branch        = (i == branch_beat);
            @(negedge clk);
        end
        mem_if.mem_rd_valid = 1'b0;
        wb_do_branch        = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (fsm_idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", fsm_idle); end
        n_cmp++; if (mem_if.mem_rd_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mem_if.mem_rd_req); end
        n_cmp++; if (update_tag_en !== 2'b00) begin n_err++; $display("FAIL rst_upd_en: got %b want 00", update_tag_en); end
        n_cmp++; if (resume_fetch !== 1'b0) begin n_err++; $display("FAIL rst_resume: got %b want 0", resume_fetch); end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
        n_cmp++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_first_miss();
        @(negedge clk);
        ift_valid = 1'b1; fetched_pc = 32'h100; valid_bits = 2'b00;
        #1;
        n_cmp++; if (cache_miss !== 1'b1) begin n_err++; $display("FAIL m1_pulse: got %b want 1", cache_miss); end
        @(negedge clk);
        ift_valid = 1'b0;
        #1;
        n_cmp++; if (cache_miss !== 1'b0) begin n_err++; $display("FAIL m1_pulse_end: got %b want 0", cache_miss); end
        n_cmp++; if (mem_if.mem_rd_req !== 1'b1) begin n_err++; $display("FAIL m1_req: got %b want 1", mem_if.mem_rd_req); end
        n_cmp++; if (mem_if.mem_rd_addr !== 32'h100) begin n_err++; $display("FAIL m1_addr: got %h want 00000100", mem_if.mem_rd_addr); end
        n_cmp++; if (fsm_idle !== 1'b0) begin n_err++; $display("FAIL m1_idle: got %b want 0", fsm_idle); end
        // stray beat while still requesting must be dropped
        mem_if.mem_rd_valid = 1'b1; mem_if.mem_rd_data = 32'hDEADBEEF;
        @(negedge clk);
        mem_if.mem_rd_valid = 1'b0;
        n_cmp++; if (mem_if.mem_rd_req !== 1'b1 || mem_if.mem_rd_addr !== 32'h100) begin
            n_err++; $display("FAIL m1_req_hold: req=%b addr=%h want 1/00000100", mem_if.mem_rd_req, mem_if.mem_rd_addr); end
        serve_fill(32'hA0, 1, -1);
        n_cmp++; if (update_tag_en !== 2'b01) begin n_err++; $display("FAIL m1_upd_en: got %b want 01", update_tag_en); end
        n_cmp++; if (update_tag_set !== 6'h08) begin n_err++; $display("FAIL m1_upd_set: got %h want 08", update_tag_set); end
        n_cmp++; if (update_tag !== 21'h0) begin n_err++; $display("FAIL m1_upd_tag: got %h want 0", update_tag); end
        @(negedge clk);
        n_cmp++; if (resume_fetch !== 1'b1 || update_tag_en !== 2'b00) begin
            n_err++; $display("FAIL m1_resume: resume=%b en=%b want 1/00", resume_fetch, update_tag_en); end
        @(negedge clk);
        n_cmp++; if (fsm_idle !== 1'b1 || resume_fetch !== 1'b0) begin
            n_err++; $display("FAIL m1_back_idle: idle=%b resume=%b want 1/0", fsm_idle, resume_fetch); end
    endtask

    task automatic test_second_miss();
        @(negedge clk);
        ift_valid = 1'b1; fetched_pc = 32'h2100; valid_bits = 2'b01; tags_read[0] = 21'h0; tags_read[1] = 21'h0;
        #1;
        n_cmp++; if (cache_miss !== 1'b1) begin n_err++; $display("FAIL m2_pulse: got %b want 1", cache_miss); end
        @(negedge clk);
        // a new miss while busy is ignored
        fetched_pc = 32'h8000; valid_bits = 2'b00;
        #1;
        n_cmp++; if (cache_miss !== 1'b0 || mem_if.mem_rd_addr !== 32'h2100) begin
            n_err++; $display("FAIL m2_busy_miss: miss=%b addr=%h want 0/00002100", cache_miss, mem_if.mem_rd_addr); end
        ift_valid = 1'b0;
        serve_fill(32'hB0, 0, -1);
        n_cmp++; if (update_tag_en !== 2'b10) begin n_err++; $display("FAIL m2_upd_en: got %b want 10", update_tag_en); end
        n_cmp++; if (update_tag !== 21'h4 || update_tag_set !== 6'h08) begin
            n_err++; $display("FAIL m2_upd_tag: tag=%h set=%h want 4/08", update_tag, update_tag_set); end
        @(negedge clk);
        n_cmp++; if (resume_fetch !== 1'b1) begin n_err++; $display("FAIL m2_resume: got %b want 1", resume_fetch); end
        @(negedge clk);
    endtask

    task automatic test_hits();
        @(negedge clk);
        ift_valid = 1'b1; valid_bits = 2'b11; tags_read[0] = 21'h0; tags_read[1] = 21'h4;
        fetched_pc = 32'h10C;
        #1;
        n_cmp++; if (cache_miss !== 1'b0) begin n_err++; $display("FAIL hit_no_miss: got %b want 0", cache_miss); end
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b1 || id_instr !== 32'hA3 || id_pc !== 32'h10C) begin
            n_err++; $display("FAIL hit_w0: v=%b instr=%h pc=%h want 1/000000a3/0000010c", id_valid, id_instr, id_pc); end
        fetched_pc = 32'h2114;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b1 || id_instr !== 32'hB5 || id_pc !== 32'h2114) begin
            n_err++; $display("FAIL hit_w1: v=%b instr=%h pc=%h want 1/000000b5/00002114", id_valid, id_instr, id_pc); end
        fetched_pc = 32'h100;
        @(negedge clk);
        n_cmp++; if (id_instr !== 32'hA0) begin n_err++; $display("FAIL hit_first_word: got %h want 000000a0", id_instr); end
        fetched_pc = 32'h11C;
        @(negedge clk);
        n_cmp++; if (id_instr !== 32'hA7) begin n_err++; $display("FAIL hit_last_word: got %h want 000000a7", id_instr); end
        fetched_pc = 32'h10C; wb_do_branch = 1'b1;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL hit_squash: got %b want 0", id_valid); end
        fetched_pc = 32'h4100;
        #1;
        n_cmp++; if (cache_miss !== 1'b0) begin n_err++; $display("FAIL branch_no_miss: got %b want 0", cache_miss); end
        @(negedge clk);
        n_cmp++; if (mem_if.mem_rd_req !== 1'b0 || fsm_idle !== 1'b1) begin
            n_err++; $display("FAIL branch_no_req: req=%b idle=%b want 0/1", mem_if.mem_rd_req, fsm_idle); end
        wb_do_branch = 1'b0; ift_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL no_fetch_valid: got %b want 0", id_valid); end
    endtask

    task automatic test_branch_in_fill();
        @(negedge clk);
        ift_valid = 1'b1; fetched_pc = 32'h4100; valid_bits = 2'b11;
        #1;
        n_cmp++; if (cache_miss !== 1'b1) begin n_err++; $display("FAIL m3_pulse: got %b want 1", cache_miss); end
        @(negedge clk);
        ift_valid = 1'b0;
        serve_fill(32'hC0, 0, 3);
        n_cmp++; if (update_tag_en !== 2'b01 || update_tag !== 21'h8) begin
            n_err++; $display("FAIL m3_upd: en=%b tag=%h want 01/8", update_tag_en, update_tag); end
        @(negedge clk);
        n_cmp++; if (resume_fetch !== 1'b1) begin n_err++; $display("FAIL m3_resume: got %b want 1", resume_fetch); end
        @(negedge clk);
        n_cmp++; if (fsm_idle !== 1'b1) begin n_err++; $display("FAIL m3_idle: got %b want 1", fsm_idle); end
    endtask

    task automatic test_reset_mid_fill();
        int saw_update;
        saw_update = 0;
        @(negedge clk);
        ift_valid = 1'b1; fetched_pc = 32'h6100; valid_bits = 2'b00;
        @(negedge clk);
        ift_valid = 1'b0; mem_if.mem_rd_ack = 1'b1;
        @(negedge clk);
        mem_if.mem_rd_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_if.mem_rd_valid = 1'b1; mem_if.mem_rd_data = 32'hD0 + 32'(i);
            @(negedge clk);
        end
        mem_if.mem_rd_data = 32'hD4;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (fsm_idle !== 1'b1 || mem_if.mem_rd_req !== 1'b0) begin
            n_err++; $display("FAIL rmid_fsm: idle=%b req=%b want 1/0", fsm_idle, mem_if.mem_rd_req); end
        n_cmp++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0) begin
            n_err++; $display("FAIL rmid_id: v=%b instr=%h pc=%h want 0/0/0", id_valid, id_instr, id_pc); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            mem_if.mem_rd_data = 32'hD5 + 32'(i);
            @(negedge clk);
            if (update_tag_en !== 2'b00 || resume_fetch !== 1'b0) saw_update++;
        end
        mem_if.mem_rd_valid = 1'b0;
        n_cmp++; if (saw_update !== 0) begin n_err++; $display("FAIL rmid_no_update: strobe cycles=%0d want 0", saw_update); end
        n_cmp++; if (fsm_idle !== 1'b1) begin n_err++; $display("FAIL rmid_idle: got %b want 1", fsm_idle); end
        ift_valid = 1'b1; fetched_pc = 32'h200;
        @(negedge clk);
        ift_valid = 1'b0;
        n_cmp++; if (mem_if.mem_rd_req !== 1'b1 || mem_if.mem_rd_addr !== 32'h200) begin
            n_err++; $display("FAIL rmid_restart: req=%b addr=%h want 1/00000200", mem_if.mem_rd_req, mem_if.mem_rd_addr); end
        serve_fill(32'hE0, 0, -1);
        n_cmp++; if (update_tag_en !== 2'b01 || update_tag_set !== 6'h10) begin
            n_err++; $display("FAIL rmid_rr_reset: en=%b set=%h want 01/10", update_tag_en, update_tag_set); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        ift_valid           = 1'b0;
        fetched_pc          = 32'h0;
        valid_bits          = '0;
        tags_read           = '0;
        wb_do_branch        = 1'b0;
        mem_if.mem_rd_ack   = 1'b0;
        mem_if.mem_rd_valid = 1'b0;
        mem_if.mem_rd_data  = 32'h0;

        test_reset();
        test_first_miss();
        test_second_miss();
        test_hits();
        test_branch_in_fill();
        test_reset_mid_fill();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
